// File: rtl/seg7_capture.sv
// Seven-segment loopback monitor: filters glitches on an active-low segment bus,
// decodes stable patterns to hex and emits one event per new stable pattern.
module seg7_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] out_val,
    output logic       out_blank,
    output logic       out_err,
    output logic       overrun,
    input  logic       clr_overrun
);

    localparam logic [6:0] BLANK   = 7'h7F;
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] CNT_PRE = 8'(STABLE_CYCLES - 1);

    typedef enum logic {EMPTY, FULL} buf_state_t;

    buf_state_t state;
    logic [6:0] seg_q;
    logic [6:0] last_rep;
    logic [7:0] cnt;

    logic       same;
    logic       event_fire;
    logic       drop;
    logic [3:0] dec_val;
    logic       dec_blank;
    logic       dec_err;

    // The event fires on the edge where cnt steps from STABLE_CYCLES-1 to STABLE_CYCLES.
    assign same       = (seg == seg_q);
    assign event_fire = same && (cnt == CNT_PRE) && (seg_q != last_rep);
    assign drop       = event_fire && (state == FULL) && !out_ready;
    assign out_valid  = (state == FULL);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        dec_val   = 4'h0;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (seg_q)
            7'h40: dec_val = 4'h0;
            7'h79: dec_val = 4'h1;
            7'h24: dec_val = 4'h2;
            7'h30: dec_val = 4'h3;
            7'h19: dec_val = 4'h4;
            7'h12: dec_val = 4'h5;
            7'h02: dec_val = 4'h6;
            7'h78: dec_val = 4'h7;
            7'h00: dec_val = 4'h8;
            7'h10: dec_val = 4'h9;
            7'h08: dec_val = 4'hA;
            7'h03: dec_val = 4'hB;
            7'h46: dec_val = 4'hC;
            7'h21: dec_val = 4'hD;
            7'h06: dec_val = 4'hE;
            7'h0E: dec_val = 4'hF;
            BLANK: dec_blank = 1'b1;
            default: dec_err = 1'b1;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= EMPTY;
            seg_q     <= BLANK;
            last_rep  <= BLANK;
            cnt       <= 8'd0;
            out_val   <= 4'h0;
            out_blank <= 1'b0;
            out_err   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            seg_q <= seg;
            if (!same)
                cnt <= 8'd0;
            else if (cnt < CNT_MAX)
                cnt <= cnt + 8'd1;

            if (event_fire)
                last_rep <= seg_q;

            case (state)
                EMPTY: begin
                    if (event_fire) begin
                        state     <= FULL;
                        out_val   <= dec_val;
                        out_blank <= dec_blank;
                        out_err   <= dec_err;
                    end
                end
                FULL: begin
                    if (out_ready && event_fire) begin
                        out_val   <= dec_val;
                        out_blank <= dec_blank;
                        out_err   <= dec_err;
                    end else if (out_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase

            // A coinciding drop beats the clear request.
            if (drop)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: directed scenarios plus random traffic, compared each
// cycle against a run-length reference model of the capture and buffer behaviour.
module tb_seg7_capture;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] out_val;
    logic       out_blank;
    logic       out_err;
    logic       overrun;
    logic       clr_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int         dec_tab [128];
    logic [6:0] held;
    int         run;
    logic [6:0] last_m;
    bit         m_valid;
    logic [3:0] m_val;
    bit         m_blank;
    bit         m_err;
    bit         m_ovr;

    logic [6:0] pool [20];

    seg7_capture #(.STABLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg        (seg),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_val    (out_val),
        .out_blank  (out_blank),
        .out_err    (out_err),
        .overrun    (overrun),
        .clr_overrun(clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        held    = 7'h7F;
        run     = 1;
        last_m  = 7'h7F;
        m_valid = 0;
        m_val   = 4'h0;
        m_blank = 0;
        m_err   = 0;
        m_ovr   = 0;
    endtask

    // A pattern is stable once it has been sampled on S+1 consecutive edges.
    task automatic model_step();
        bit ev;
        bit dr;
        if (!rst_n) begin
            model_reset();
        end else begin
            ev = 0;
            dr = 0;
            if (seg == held) run++;
            else begin
                held = seg;
                run  = 1;
            end
            if (run == S + 1 && held != last_m) ev = 1;
            if (ev) begin
                last_m = held;
                if (!m_valid || out_ready) begin
                    m_valid = 1;
                    m_blank = (held == 7'h7F);
                    m_err   = (held != 7'h7F) && (dec_tab[held] < 0);
                    m_val   = (dec_tab[held] < 0) ? 4'h0 : 4'(dec_tab[held]);
                end else begin
                    dr = 1;
                end
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
            if (dr) m_ovr = 1;
            else if (clr_overrun) m_ovr = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("m_valid", out_valid, m_valid);
        check("m_val",   out_val,   m_val);
        check("m_blank", out_blank, m_blank);
        check("m_err",   out_err,   m_err);
        check("m_ovr",   overrun,   m_ovr);
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        seg = p;
        repeat (n) tick();
    endtask

    initial begin
        logic [6:0] digits [16];
        digits = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        for (int i = 0; i < 128; i++) dec_tab[i] = -1;
        for (int i = 0; i < 16; i++) begin
            dec_tab[digits[i]] = i;
            pool[i] = digits[i];
        end
        pool[16] = 7'h7F;
        pool[17] = 7'h4C;
        pool[18] = 7'h55;
        pool[19] = 7'h2A;
        model_reset();

        rst_n = 1'b0; seg = 7'h7F; out_ready = 1'b0; clr_overrun = 1'b0;
        repeat (2) tick();
        check("rst_valid", out_valid, 0);
        check("rst_ovr",   overrun,   0);
        rst_n = 1'b1;
        hold(7'h7F, 20);
        check("blank_idle", out_valid, 0);

        // Latency and single event for a held digit
        out_ready = 1'b1;
        hold(7'h30, 4);
        check("lat_early", out_valid, 0);
        tick();
        check("lat_valid", out_valid, 1);
        check("lat_val",   out_val,   3);
        check("lat_flags", {out_blank, out_err}, 0);
        tick();
        check("lat_pop", out_valid, 0);
        hold(7'h30, 50);
        check("no_repeat", out_valid, 0);

        // Glitch back to the last reported pattern
        hold(7'h24, 2);
        hold(7'h30, 10);
        check("glitch", out_valid, 0);
        hold(7'h0E, 5);
        check("f_val", out_val, 4'hF);
        check("f_valid", out_valid, 1);
        tick();

        // Overrun while full, then drain and clear
        out_ready = 1'b0;
        hold(7'h02, 5);
        check("six_val", out_val, 6);
        hold(7'h4C, 5);
        check("ovr_set", overrun, 1);
        check("ovr_hold", out_val, 6);
        out_ready = 1'b1;
        tick();
        check("drain", out_valid, 0);
        out_ready = 1'b0;
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("ovr_clr", overrun, 0);

        // Accept and load on the same edge
        hold(7'h79, 5);
        check("one_val", out_val, 1);
        hold(7'h7F, 4);
        out_ready = 1'b1;
        tick();
        check("coll_valid", out_valid, 1);
        check("coll_blank", out_blank, 1);
        check("coll_ovr",   overrun,   0);
        tick();

        // Error pattern, reset while full, then digit 0
        out_ready = 1'b0;
        hold(7'h4C, 5);
        check("err_flag", out_err, 1);
        check("err_val",  out_val, 0);
        rst_n = 1'b0;
        tick();
        check("mid_rst", {out_valid, out_val, out_blank, out_err, overrun}, 0);
        rst_n = 1'b1;
        hold(7'h40, 5);
        check("zero_valid", out_valid, 1);
        check("zero_flags", {out_val, out_blank, out_err}, 0);
        out_ready = 1'b1;
        tick();

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            int n;
            seg = pool[$urandom_range(0, 19)];
            n = $urandom_range(1, 7);
            for (int j = 0; j < n; j++) begin
                out_ready   = ($urandom_range(0, 2) != 0);
                clr_overrun = ($urandom_range(0, 15) == 0);
                rst_n       = ($urandom_range(0, 199) != 0);
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
